// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, LSB-first data, optional even/odd parity and one or two stop bits.
// Registered serial and status outputs. Frames can run back-to-back when data_valid is held high.
module uart_tx_engine #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk1,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  parity_en,
  input  logic                  parity_type,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  tx_ack,
  output logic                  frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state_reg, state_next;
  logic [CW-1:0]           clk_cnt_reg, clk_cnt_next;
  logic [BW-1:0]           bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0]   data_reg, data_next;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
  logic                    par_en_reg, par_en_next;
  logic                    par_type_reg, par_type_next;
  logic                    accept;
  logic                    bit_end;
  logic                    tx_next, busy_next, ack_next, done_next;

  assign bit_end = (clk_cnt_reg == CLK_LAST);

  always_comb begin
    state_next    = state_reg;
    clk_cnt_next  = clk_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    data_next     = data_reg;
    shift_next    = shift_reg;
    par_en_next   = par_en_reg;
    par_type_next = par_type_reg;
    accept        = 1'b0;

    case (state_reg)
      IDLE: accept = data_valid;
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          clk_cnt_next = '0;
          bit_cnt_next = '0;
        end else begin
          clk_cnt_next = clk_cnt_reg + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          shift_next   = shift_reg >> 1;
          if (bit_cnt_reg == DATA_LAST) begin
            bit_cnt_next = '0;
            state_next   = par_en_reg ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + BW'(1);
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CW'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next   = STOP;
          clk_cnt_next = '0;
          bit_cnt_next = '0;
        end else begin
          clk_cnt_next = clk_cnt_reg + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          if (bit_cnt_reg == STOP_LAST) begin
            bit_cnt_next = '0;
            state_next   = IDLE;
            accept       = data_valid;
          end else begin
            bit_cnt_next = bit_cnt_reg + BW'(1);
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next   = IDLE;
        clk_cnt_next = '0;
        bit_cnt_next = '0;
      end
    endcase

    if (accept) begin
      state_next    = START;
      clk_cnt_next  = '0;
      bit_cnt_next  = '0;
      data_next     = p_data;
      shift_next    = p_data;
      par_en_next   = parity_en;
      par_type_next = parity_type;
    end

    // Outputs are derived from the next state so the registered pins line up with the state
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = (^data_next) ^ par_type_next;
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
    ack_next  = accept;
    done_next = (state_next == STOP) && (clk_cnt_next == CLK_LAST) && (bit_cnt_next == STOP_LAST);
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      clk_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      data_reg     <= '0;
      shift_reg    <= '0;
      par_en_reg   <= 1'b0;
      par_type_reg <= 1'b0;
      tx_out       <= 1'b1;
      busy         <= 1'b0;
      tx_ack       <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clk_cnt_reg  <= clk_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      data_reg     <= data_next;
      shift_reg    <= shift_next;
      par_en_reg   <= par_en_next;
      par_type_reg <= par_type_next;
      tx_out       <= tx_next;
      busy         <= busy_next;
      tx_ack       <= ack_next;
      frame_done   <= done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: one instance with one stop bit, one with two,
// both at 4 clocks per bit; every observed cycle is compared to hand-written frames.
module tb_uart_tx_engine;

  logic       clk1 = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       dv1, dv2;
  logic       parity_en, parity_type;
  logic       tx1, busy1, ack1, done1;
  logic       tx2, busy2, ack2, done2;
  logic       sel;
  logic       tx_obs, busy_obs, ack_obs, done_obs;
  int         checks = 0;
  int         errors = 0;

  always #5 clk1 = ~clk1;

  uart_tx_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut1 (
    .clk1(clk1), .rst(rst), .p_data(p_data), .data_valid(dv1),
    .parity_en(parity_en), .parity_type(parity_type),
    .tx_out(tx1), .busy(busy1), .tx_ack(ack1), .frame_done(done1)
  );

  uart_tx_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
    .clk1(clk1), .rst(rst), .p_data(p_data), .data_valid(dv2),
    .parity_en(parity_en), .parity_type(parity_type),
    .tx_out(tx2), .busy(busy2), .tx_ack(ack2), .frame_done(done2)
  );

  assign tx_obs   = sel ? tx2   : tx1;
  assign busy_obs = sel ? busy2 : busy1;
  assign ack_obs  = sel ? ack2  : ack1;
  assign done_obs = sel ? done2 : done1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk1);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " tx"}, tx_obs, 1);
    chk({tag, " busy"}, busy_obs, 0);
    chk({tag, " ack"}, ack_obs, 0);
    chk({tag, " done"}, done_obs, 0);
  endtask

  // seq lists the frame bits in transmit order, leftmost bit first on the line
  task automatic run_frame(input string tag, input logic [15:0] seq, input int nbits, input logic drop_dv);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("%s tx b%0d c%0d", tag, b, c), tx_obs, seq[nbits-1-b]);
        chk($sformatf("%s busy b%0d c%0d", tag, b, c), busy_obs, 1);
        chk($sformatf("%s ack b%0d c%0d", tag, b, c), ack_obs, (b == 0 && c == 0));
        chk($sformatf("%s done b%0d c%0d", tag, b, c), done_obs, (b == nbits-1 && c == 3));
        if (b == 0 && c == 0 && drop_dv) begin
          dv1 = 1'b0;
          dv2 = 1'b0;
        end
        tick();
      end
    end
    $display("frame %s: %0d bits, %0d cycles checked", tag, nbits, nbits*4);
  endtask

  initial begin
    rst = 1'b0; dv1 = 1'b0; dv2 = 1'b0; sel = 1'b0;
    p_data = 8'h00; parity_en = 1'b0; parity_type = 1'b0;
    tick(); tick();
    chk_idle("reset1");
    sel = 1'b1; chk_idle("reset2"); sel = 1'b0;
    rst = 1'b1;
    tick(); tick();
    chk_idle("idle1");

    // 0xA5 even parity: parity bit 0
    p_data = 8'hA5; parity_en = 1'b1; parity_type = 1'b0; dv1 = 1'b1;
    tick();
    run_frame("a5_even", 16'(11'b0_10100101_0_1), 11, 1'b1);
    chk_idle("after_a5_even");

    // 0xA5 odd parity; inputs disturbed mid-frame must not matter
    p_data = 8'hA5; parity_en = 1'b1; parity_type = 1'b1; dv1 = 1'b1;
    tick();
    p_data = 8'h00; parity_en = 1'b0; parity_type = 1'b0;
    run_frame("a5_odd", 16'(11'b0_10100101_1_1), 11, 1'b1);
    chk_idle("after_a5_odd");
    tick();
    chk_idle("idle2");

    // 0x3C, no parity, two stop bits
    sel = 1'b1;
    p_data = 8'h3C; parity_en = 1'b0; parity_type = 1'b0; dv2 = 1'b1;
    tick();
    run_frame("3c_2stop", 16'(11'b0_00111100_1_1), 11, 1'b1);
    chk_idle("after_3c");
    sel = 1'b0;

    // Back-to-back 0x01 then 0xFF with data_valid held high, no parity
    p_data = 8'h01; parity_en = 1'b0; dv1 = 1'b1;
    tick();
    p_data = 8'hFF;
    run_frame("b2b_01", 16'(10'b0_10000000_1), 10, 1'b0);
    run_frame("b2b_ff", 16'(10'b0_11111111_1), 10, 1'b1);
    chk_idle("after_b2b");

    // Reset during data bit 3, then a clean 0x5A frame
    p_data = 8'h96; parity_en = 1'b1; parity_type = 1'b0; dv1 = 1'b1;
    tick();
    dv1 = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    chk("pre_reset busy", busy1, 1);
    chk("pre_reset tx bit3", tx1, 0);
    p_data = 8'h00;
    #2 rst = 1'b0;
    #1;
    chk_idle("async_reset");
    tick(); tick();
    chk_idle("held_reset");
    rst = 1'b1;
    tick();
    chk_idle("post_reset");
    p_data = 8'h5A; parity_en = 1'b1; parity_type = 1'b0; dv1 = 1'b1;
    tick();
    run_frame("5a_after_reset", 16'(11'b0_01011010_0_1), 11, 1'b1);
    chk_idle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
